// File: rtl/sram_dma_copy.sv
// sram_dma_copy
// -----------------------------------------------------------------------------
// Bus initiator that copies or fills blocks of 32-bit words through the
// strobe/wait command port of the SRAM controller. A CPU-side register block
// configures an operation and fires it with a one-cycle start pulse. Each word
// costs one read (copy only) and one write. Completion is signalled by a
// one-cycle done pulse.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   start           : one-cycle request, accepted only while idle
//   mode            : 0 = copy src->dst, 1 = fill dst with fill_data
//   dir             : 0 = ascending addresses, 1 = descending
//   src_addr        : first source word address (unused for fill)
//   dst_addr        : first destination word address
//   count           : number of words, 0 = no transfer
//   fill_data       : fill pattern
//   abort           : stop request, honoured at the next word boundary
//   busy            : operation in progress
//   done            : one-cycle completion pulse
//   aborted         : last operation was stopped by abort
//   bus_addr        : command word address
//   bus_wrdata      : write data
//   bus_bytesel     : byte enables, all ones during a transaction
//   bus_wren        : 1 = write transaction
//   bus_strobe      : transaction request
//   bus_wait        : responder stall
//   bus_rddata      : read data, valid at the completing edge
// -----------------------------------------------------------------------------
module sram_dma_copy #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  dir,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic [31:0]           fill_data,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wrdata,
    output logic [3:0]            bus_bytesel,
    output logic                  bus_wren,
    output logic                  bus_strobe,
    input  logic                  bus_wait,
    input  logic [31:0]           bus_rddata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched configuration and walking pointers
    logic                  mode_q, mode_d;
    logic                  dir_q, dir_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic [31:0]           fill_q, fill_d;
    logic                  abort_pend_q, abort_pend_d;

    // Registered outputs
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]           bus_wrdata_q, bus_wrdata_d;
    logic [3:0]            bus_bytesel_q, bus_bytesel_d;
    logic                  bus_wren_q, bus_wren_d;
    logic                  bus_strobe_q, bus_strobe_d;

    logic                  xfer_done;
    logic                  last_word;
    logic                  abort_now;
    logic                  stop_now;
    logic [ADDR_WIDTH-1:0] src_next;
    logic [ADDR_WIDTH-1:0] dst_next;

    // A transaction finishes on any edge where it is requested and not stalled.
    assign xfer_done = bus_strobe_q & ~bus_wait;
    assign last_word = (rem_q == ADDR_WIDTH'(1));
    // An abort arriving in the same cycle as a write completion still counts,
    // so the stop lands on the nearest word boundary.
    assign abort_now = abort_pend_q | (busy_q & abort);
    assign stop_now  = last_word | abort_now;

    // Pointer arithmetic wraps naturally at the address width.
    assign src_next = dir_q ? (src_q - ADDR_WIDTH'(1)) : (src_q + ADDR_WIDTH'(1));
    assign dst_next = dir_q ? (dst_q - ADDR_WIDTH'(1)) : (dst_q + ADDR_WIDTH'(1));

    // -------------------------------------------------------------------------
    // State register (and all other flops)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            dir_q         <= 1'b0;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            fill_q        <= '0;
            abort_pend_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_wrdata_q  <= '0;
            bus_bytesel_q <= '0;
            bus_wren_q    <= 1'b0;
            bus_strobe_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            dir_q         <= dir_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            rem_q         <= rem_d;
            fill_q        <= fill_d;
            abort_pend_q  <= abort_pend_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            bus_addr_q    <= bus_addr_d;
            bus_wrdata_q  <= bus_wrdata_d;
            bus_bytesel_q <= bus_bytesel_d;
            bus_wren_q    <= bus_wren_d;
            bus_strobe_q  <= bus_strobe_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && (count != '0)) begin
                    state_d = mode ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (xfer_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (xfer_done) begin
                    if (stop_now) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = mode_q ? S_WRITE : S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        mode_d        = mode_q;
        dir_d         = dir_q;
        src_d         = src_q;
        dst_d         = dst_q;
        rem_d         = rem_q;
        fill_d        = fill_q;
        abort_pend_d  = abort_now;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = aborted_q;
        bus_addr_d    = bus_addr_q;
        bus_wrdata_d  = bus_wrdata_q;
        bus_bytesel_d = bus_bytesel_q;
        bus_wren_d    = bus_wren_q;
        bus_strobe_d  = bus_strobe_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    dir_d        = dir;
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    rem_d        = count;
                    fill_d       = fill_data;
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (count == '0) begin
                        // Empty request: acknowledge without touching the bus.
                        done_d = 1'b1;
                    end else begin
                        busy_d        = 1'b1;
                        bus_strobe_d  = 1'b1;
                        bus_bytesel_d = 4'hF;
                        bus_wren_d    = mode;
                        bus_addr_d    = mode ? dst_addr : src_addr;
                        bus_wrdata_d  = mode ? fill_data : bus_wrdata_q;
                    end
                end
            end

            S_READ: begin
                // The write data register doubles as the word buffer; the
                // write is issued back-to-back with strobe kept high.
                if (xfer_done) begin
                    bus_addr_d   = dst_q;
                    bus_wren_d   = 1'b1;
                    bus_wrdata_d = bus_rddata;
                end
            end

            S_WRITE: begin
                if (xfer_done) begin
                    rem_d = rem_q - ADDR_WIDTH'(1);
                    src_d = src_next;
                    dst_d = dst_next;
                    if (stop_now) begin
                        bus_strobe_d  = 1'b0;
                        bus_wren_d    = 1'b0;
                        bus_bytesel_d = 4'h0;
                        busy_d        = 1'b0;
                        done_d        = 1'b1;
                        abort_pend_d  = 1'b0;
                        // A stop that coincides with the final word is a
                        // normal completion.
                        aborted_d     = abort_now & ~last_word;
                    end else if (mode_q) begin
                        bus_addr_d   = dst_next;
                        bus_wrdata_d = fill_q;
                    end else begin
                        bus_addr_d = src_next;
                        bus_wren_d = 1'b0;
                    end
                end
            end

            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wrdata  = bus_wrdata_q;
    assign bus_bytesel = bus_bytesel_q;
    assign bus_wren    = bus_wren_q;
    assign bus_strobe  = bus_strobe_q;

endmodule

// File: tb/tb_sram_dma_copy.sv
module tb_sram_dma_copy;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset, start, mode, dir, abort, bus_wait;
    logic [AW-1:0] src_addr, dst_addr, count;
    logic [31:0]   fill_data, bus_rddata;
    logic          busy, done, aborted, bus_wren, bus_strobe;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wrdata;
    logic [3:0]    bus_bytesel;

    always #5 clk = ~clk;

    sram_dma_copy #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .dir(dir),
        .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
        .bus_bytesel(bus_bytesel), .bus_wren(bus_wren), .bus_strobe(bus_strobe),
        .bus_wait(bus_wait), .bus_rddata(bus_rddata)
    );

    int checks = 0;
    int errors = 0;

    // Responder memory (what the DUT actually did) and model memory (what it should do)
    logic [31:0] mem  [int];
    logic [31:0] mmem [int];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
    } xact_t;

    xact_t         q[$];
    logic [AW-1:0] wlog[$];
    xact_t         ck_e;
    logic [31:0]   ck_ed;
    int            ck_off;
    bit            op_mode;
    logic [31:0]   op_fill, rd_tmp;
    bit            abort_flag, done_exp, aborted_exp, busy_exp;
    int            words_done = 0, done_count = 0, cyc = 0;
    int            first_strobe_cyc = -1, done_cyc = 0, accept_cyc = 0, busy_cnt = 0;
    int            wait_mode = 0, wait_n = 0, wcnt = 0;
    bit            prev_hold;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_data;
    logic          h_wren;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ 32'(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : dflt(a);
    endfunction

    function automatic logic [31:0] mmem_rd(input logic [AW-1:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : dflt(a);
    endfunction

    // Responder + per-cycle compare against the word-level model
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            abort_flag = 0;
            done_exp   = 0;
            busy_exp   = 0;
            prev_hold  = 0;
            bus_wait   = 0;
            wcnt       = 0;
        end else begin
            chk("done", done, done_exp);
            if (done) begin
                done_count++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
                chk("aborted_at_done", aborted, aborted_exp);
            end
            done_exp = 0;
            if (busy_exp) chk("busy_after_start", busy, 1);
            busy_exp = 0;
            chk("strobe_eq_busy", bus_strobe, busy);
            if (busy) busy_cnt++;
            if (bus_strobe) begin
                chk("bytesel", bus_bytesel, 4'hF);
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            end
            if (prev_hold) begin
                chk("hold_strobe", bus_strobe, 1);
                chk("hold_addr", bus_addr, h_addr);
                chk("hold_wren", bus_wren, h_wren);
                chk("hold_wrdata", bus_wrdata, h_data);
            end
            if (busy && abort) abort_flag = 1;

            if (start && !busy) begin
                accept_cyc       = cyc;
                abort_flag       = 0;
                aborted_exp      = 0;
                words_done       = 0;
                first_strobe_cyc = -1;
                busy_cnt         = 0;
                wlog.delete();
                q.delete();
                op_mode = mode;
                op_fill = fill_data;
                if (count == '0) begin
                    done_exp = 1;
                end else begin
                    busy_exp = 1;
                    for (int i = 0; i < int'(count); i++) begin
                        ck_off = dir ? -i : i;
                        if (!mode) begin
                            ck_e.wr   = 1'b0;
                            ck_e.addr = AW'(int'(src_addr) + ck_off);
                            q.push_back(ck_e);
                        end
                        ck_e.wr   = 1'b1;
                        ck_e.addr = AW'(int'(dst_addr) + ck_off);
                        q.push_back(ck_e);
                    end
                end
            end

            if (bus_strobe) begin
                if (wait_mode == 1) begin
                    bus_wait = (wcnt < wait_n);
                    wcnt     = bus_wait ? wcnt + 1 : 0;
                end else if (wait_mode == 2) begin
                    bus_wait = ($urandom_range(0, 2) == 0);
                end else begin
                    bus_wait = 0;
                end
            end else begin
                bus_wait = 0;
            end

            if (bus_strobe && !bus_wait) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer got addr %h want no transaction", bus_addr);
                end else begin
                    ck_e = q.pop_front();
                    chk("xfer_wren", bus_wren, ck_e.wr);
                    chk("xfer_addr", bus_addr, ck_e.addr);
                    if (!ck_e.wr) begin
                        rd_tmp     = mmem_rd(ck_e.addr);
                        bus_rddata = mem_rd(bus_addr);
                    end else begin
                        ck_ed = op_mode ? op_fill : rd_tmp;
                        chk("xfer_wrdata", bus_wrdata, ck_ed);
                        mmem[int'(ck_e.addr)] = ck_ed;
                        mem[int'(bus_addr)]   = bus_wrdata;
                        wlog.push_back(bus_addr);
                        words_done++;
                        if (abort_flag || q.size() == 0) begin
                            aborted_exp = abort_flag && (q.size() != 0);
                            q.delete();
                            done_exp   = 1;
                            abort_flag = 0;
                        end
                    end
                end
            end
            prev_hold = bus_strobe && bus_wait;
            h_addr    = bus_addr;
            h_wren    = bus_wren;
            h_data    = bus_wrdata;
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
        mem[int'(a)]  = v;
        mmem[int'(a)] = v;
    endtask

    task automatic do_start(input bit m, input bit d, input logic [AW-1:0] s,
                            input logic [AW-1:0] dd, input logic [AW-1:0] n,
                            input logic [31:0] f);
        @(posedge clk); #2;
        mode = m; dir = d; src_addr = s; dst_addr = dd; count = n; fill_data = f;
        start = 1;
        @(posedge clk); #2;
        start = 0;
    endtask

    task automatic wait_done(input int dc0, input int budget);
        int k;
        k = 0;
        while (done_count == dc0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_count == dc0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got no done in %0d cycles want done pulse", budget);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0, k, ab_at;
        bit use_ab;
        logic [AW-1:0] exp_w [4];
        logic [AW-1:0] ra;

        reset = 1; start = 0; mode = 0; dir = 0; abort = 0;
        src_addr = 0; dst_addr = 0; count = 0; fill_data = 0;
        bus_wait = 0; bus_rddata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_strobe", bus_strobe, 0);
        chk("rst_wren", bus_wren, 0);
        chk("rst_bytesel", bus_bytesel, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wrdata", bus_wrdata, 0);
        @(posedge clk); #2;
        reset = 0;

        // Fill 4 words, zero wait
        wait_mode = 0;
        dc0 = done_count;
        do_start(1, 0, 0, 'h100, 4, 32'hDEADBEEF);
        wait_done(dc0, 100);
        for (int i = 0; i < 4; i++) chk("fill_mem", mem_rd(AW'('h100 + i)), 32'hDEADBEEF);
        chk("fill_start_lat", first_strobe_cyc - accept_cyc, 1);
        chk("fill_done_lat", done_cyc - first_strobe_cyc, 4);
        chk("fill_words", words_done, 4);

        // Copy 3 words, 2 wait cycles per access
        preload(0, 32'h11111111);
        preload(1, 32'h22222222);
        preload(2, 32'h33333333);
        wait_mode = 1; wait_n = 2;
        dc0 = done_count;
        do_start(0, 0, 0, 'h200, 3, 0);
        wait_done(dc0, 200);
        chk("copy_m200", mem_rd('h200), 32'h11111111);
        chk("copy_m201", mem_rd('h201), 32'h22222222);
        chk("copy_m202", mem_rd('h202), 32'h33333333);
        chk("copy_nwr", wlog.size(), 3);
        chk("copy_done_lat", done_cyc - first_strobe_cyc, 18);

        // Zero count
        wait_mode = 0;
        dc0 = done_count;
        do_start(0, 0, 5, 6, 0, 0);
        wait_done(dc0, 10);
        chk("zero_done_lat", done_cyc - accept_cyc, 1);
        chk("zero_busy_cnt", busy_cnt, 0);
        chk("zero_strobe", first_strobe_cyc, -1);
        chk("zero_aborted", aborted, 0);

        // Abort in the middle of the 5th read of a 100-word copy
        wait_mode = 1; wait_n = 2;
        dc0 = done_count;
        do_start(0, 0, 'h400, 'h800, 100, 0);
        k = 0;
        while (words_done < 4 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        chk("abort_reach4", words_done, 4);
        @(posedge clk); #2;
        @(posedge clk); #2;
        abort = 1;
        @(posedge clk); #2;
        abort = 0;
        wait_done(dc0, 500);
        chk("abort_words", words_done, 5);
        chk("abort_nwr", wlog.size(), 5);
        chk("abort_flag", aborted, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("abort_sticky", aborted, 1);
        dc0 = done_count;
        do_start(0, 0, 0, 0, 0, 0);
        wait_done(dc0, 10);
        chk("abort_cleared", aborted, 0);

        // Descending overlapping copy
        for (int a = 'h0D; a <= 'h13; a++) preload(AW'(a), 32'h1000_0000 + 32'(a));
        wait_mode = 2;
        dc0 = done_count;
        do_start(0, 1, 'h10, 'h12, 4, 0);
        wait_done(dc0, 200);
        chk("ovl_m12", mem_rd('h12), 32'h10000010);
        chk("ovl_m11", mem_rd('h11), 32'h1000000F);
        chk("ovl_m10", mem_rd('h10), 32'h1000000E);
        chk("ovl_m0f", mem_rd('h0F), 32'h1000000D);

        // Wrap-around fill, with a start during busy that must be ignored
        wait_mode = 1; wait_n = 1;
        dc0 = done_count;
        do_start(1, 0, 0, 'h1FFFE, 4, 32'hCAFE0001);
        mode = 0; dst_addr = 'h55; count = 9; fill_data = 0; start = 1;
        @(posedge clk); #2;
        start = 0;
        wait_done(dc0, 100);
        exp_w[0] = 'h1FFFE; exp_w[1] = 'h1FFFF; exp_w[2] = 'h00000; exp_w[3] = 'h00001;
        chk("wrap_nwr", wlog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", wlog[i], exp_w[i]);
            chk("wrap_data", mem_rd(exp_w[i]), 32'hCAFE0001);
        end
        chk("ignored_start_mem", mem_rd('h55), dflt('h55));

        // Randomized operations
        for (int n = 0; n < 12; n++) begin
            wait_mode = $urandom_range(0, 2);
            wait_n    = $urandom_range(0, 3);
            use_ab    = ($urandom_range(0, 2) == 0);
            ab_at     = $urandom_range(0, 40);
            ra        = AW'($urandom);
            dc0 = done_count;
            do_start($urandom_range(0, 1), $urandom_range(0, 1), ra, AW'($urandom),
                     AW'($urandom_range(1, 20)), $urandom);
            k = 0;
            while (done_count == dc0 && k < 3000) begin
                abort = (use_ab && k == ab_at);
                @(posedge clk); #2;
                k++;
            end
            abort = 0;
            if (done_count == dc0) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout got no done want done pulse (op %0d)", n);
            end
            repeat (2) @(posedge clk);
            #2;
        end

        // Reset in the middle of a fill
        wait_mode = 0;
        do_start(1, 0, 0, 'h3000, 30, 32'h5A5A5A5A);
        repeat (5) @(posedge clk);
        #2;
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        @(negedge clk); #1;
        chk("midrst_strobe", bus_strobe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_wren", bus_wren, 0);
        dc0 = done_count;
        do_start(1, 1, 0, 'h3100, 2, 32'h77777777);
        wait_done(dc0, 50);
        chk("postrst_m3100", mem_rd('h3100), 32'h77777777);
        chk("postrst_m30ff", mem_rd('h30FF), 32'h77777777);

        foreach (mmem[a]) chk("mem_vs_model", mem_rd(AW'(a)), mmem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
